// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: datapath width, memory-stage FSM states
// and the control-bit bundle carried from EX into MEM.
package legv8_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic MemRead;
    logic MemWrite;
    logic MemtoReg;
    logic RegWrite;
    logic Branch;
    logic UncondBranch;
    logic CBNZ;
  } ctrl_t;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic misaligned(input logic [2:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline latch: captures the EX results when the MEM stage accepts
// an instruction and holds them for the whole memory access.
module ex_mem_reg import legv8_pkg::*; #(
  parameter int W = legv8_pkg::WORD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] alu_out_i,
  input  logic [W-1:0] br_tgt_i,
  input  logic [W-1:0] st_data_i,
  input  logic         z_i,
  input  logic [4:0]   rd_i,
  input  ctrl_t        ctrl_i,
  output logic [W-1:0] alu_out_o,
  output logic [W-1:0] br_tgt_o,
  output logic [W-1:0] st_data_o,
  output logic         z_o,
  output logic [4:0]   rd_o,
  output ctrl_t        ctrl_o
);

  logic [W-1:0] alu_out_q, br_tgt_q, st_data_q;
  logic         z_q;
  logic [4:0]   rd_q;
  ctrl_t        ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      br_tgt_q  <= '0;
      st_data_q <= '0;
      z_q       <= 1'b0;
      rd_q      <= '0;
      ctrl_q    <= '0;
    end else if (load_i) begin
      alu_out_q <= alu_out_i;
      br_tgt_q  <= br_tgt_i;
      st_data_q <= st_data_i;
      z_q       <= z_i;
      rd_q      <= rd_i;
      ctrl_q    <= ctrl_i;
    end
  end

  assign alu_out_o = alu_out_q;
  assign br_tgt_o  = br_tgt_q;
  assign st_data_o = st_data_q;
  assign z_o       = z_q;
  assign rd_o      = rd_q;
  assign ctrl_o    = ctrl_q;

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: performs LDUR/STUR over a request/ready port,
// resolves branches and emits a one-cycle writeback beat.
module mem_stage import legv8_pkg::*; #(
  parameter int WORD    = legv8_pkg::WORD,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [WORD-1:0] ALUOut,
  input  logic [WORD-1:0] ALU_res,
  input  logic [WORD-1:0] r_data2,
  input  logic            Z,
  input  logic [4:0]      rd,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  input  logic            Branch,
  input  logic            UncondBranch,
  input  logic            CBNZ,
  output logic            dm_req,
  output logic            dm_we,
  output logic [WORD-1:0] dm_addr,
  output logic [WORD-1:0] dm_wdata,
  input  logic            dm_ready,
  input  logic [WORD-1:0] dm_rdata,
  output logic            wb_valid,
  output logic [WORD-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_RegWrite,
  output logic            PCSrc,
  output logic [WORD-1:0] br_target,
  output logic            align_err,
  output logic            bus_err
);

  localparam int CW = $clog2(TIMEOUT);

  mem_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            align_q, align_d;
  logic            bus_q, bus_d;
  logic [WORD-1:0] rdata_q, rdata_d;

  logic            accept;
  ctrl_t           ctrl_in, ctrl_q;
  logic [WORD-1:0] alu_q, tgt_q, wdata_q;
  logic            z_q;
  logic [4:0]      rd_q;

  assign ctrl_in = '{MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ};
  assign accept  = ex_valid && (state_q == IDLE);

  ex_mem_reg #(.W(WORD)) u_latch (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .alu_out_i (ALUOut),
    .br_tgt_i  (ALU_res),
    .st_data_i (r_data2),
    .z_i       (Z),
    .rd_i      (rd),
    .ctrl_i    (ctrl_in),
    .alu_out_o (alu_q),
    .br_tgt_o  (tgt_q),
    .st_data_o (wdata_q),
    .z_o       (z_q),
    .rd_o      (rd_q),
    .ctrl_o    (ctrl_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    align_d = align_q;
    bus_d   = bus_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          align_d = 1'b0;
          bus_d   = 1'b0;
          if (!(MemRead || MemWrite)) begin
            state_d = DONE;
          end else if (misaligned(ALUOut[2:0])) begin
            state_d = DONE;
            align_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A ready in the final wait cycle still wins over the timeout.
        if (dm_ready) begin
          rdata_d = dm_rdata;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        align_d = 1'b0;
        bus_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      align_q <= 1'b0;
      bus_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
    end
  end

  logic in_done;
  assign in_done = (state_q == DONE);

  assign ex_ready    = (state_q == IDLE);
  assign dm_req      = (state_q == ACCESS);
  assign dm_we       = dm_req && ctrl_q.MemWrite;
  assign dm_addr     = alu_q;
  assign dm_wdata    = wdata_q;
  assign wb_valid    = in_done;
  assign wb_data     = ctrl_q.MemtoReg ? rdata_q : alu_q;
  assign wb_rd       = rd_q;
  assign wb_RegWrite = in_done && ctrl_q.RegWrite && !align_q && !bus_q;
  assign PCSrc       = in_done && (ctrl_q.UncondBranch || (ctrl_q.Branch && (z_q ^ ctrl_q.CBNZ)));
  assign br_target   = tgt_q;
  assign align_err   = in_done && align_q;
  assign bus_err     = in_done && bus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready;
  logic [63:0] ALUOut, ALU_res, r_data2;
  logic        Z;
  logic [4:0]  rd;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ;
  logic        dm_req, dm_we, dm_ready;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_RegWrite, PCSrc, align_err, bus_err;
  logic [63:0] wb_data, br_target;
  logic [4:0]  wb_rd;

  mem_stage #(.WORD(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALUOut(ALUOut), .ALU_res(ALU_res), .r_data2(r_data2), .Z(Z), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Branch(Branch), .UncondBranch(UncondBranch), .CBNZ(CBNZ),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .PCSrc(PCSrc), .br_target(br_target), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // control vector order: {MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ}
  localparam logic [6:0] C_LDUR = 7'b1011000;
  localparam logic [6:0] C_STUR = 7'b0100000;
  localparam logic [6:0] C_ADD  = 7'b0001000;
  localparam logic [6:0] C_CBZ  = 7'b0000100;
  localparam logic [6:0] C_CBNZ = 7'b0000101;
  localparam logic [6:0] C_B    = 7'b0000010;

  typedef struct {
    logic [63:0] alu, tgt, wdata, rdata;
    logic        z;
    logic [4:0]  rd;
    logic [6:0]  c;
    int          dly;   // index of the dm_req cycle that sees dm_ready; NEVER = tied low
  } op_t;

  typedef struct {
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        rw, pcs, al, be;
    int          req, lat;
  } exp_t;

  typedef struct {
    logic [63:0] wb_data, br_target;
    logic [4:0]  wb_rd;
    logic        rw, pcs, al, be;
    int          req, lat;
    bit          got, hold_ok, busy_ok, pulse_ok;
  } obs_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [63:0] alu, tgt, wdata, rdata, input logic z,
                                input logic [4:0] r, input logic [6:0] c, input int dly);
    op_t o;
    o.alu = alu; o.tgt = tgt; o.wdata = wdata; o.rdata = rdata;
    o.z = z; o.rd = r; o.c = c; o.dly = dly;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] d, input logic [4:0] r,
                                  input logic rw, pcs, al, be, input int req, lat);
    exp_t e;
    e.wb_data = d; e.wb_rd = r; e.rw = rw; e.pcs = pcs; e.al = al; e.be = be;
    e.req = req; e.lat = lat;
    return e;
  endfunction

  // Transaction-level reference: outcome of one instruction from the stage's rules.
  function automatic exp_t predict(input op_t o);
    exp_t e;
    logic mr, mw, m2r, rw, br, ub, cbnz;
    {mr, mw, m2r, rw, br, ub, cbnz} = o.c;
    e = mk_exp(o.alu, o.rd, rw, ub | (br & (o.z ^ cbnz)), 1'b0, 1'b0, 0, 1);
    if (mr || mw) begin
      if (o.alu % 8 != 0) begin
        e.al = 1'b1; e.rw = 1'b0;
      end else if (o.dly < TIMEOUT) begin
        e.req = o.dly + 1; e.lat = o.dly + 2;
        e.wb_data = m2r ? o.rdata : o.alu;
      end else begin
        e.be = 1'b1; e.rw = 1'b0; e.req = TIMEOUT; e.lat = TIMEOUT + 1;
      end
    end
    return e;
  endfunction

  task automatic scramble_inputs();
    ALUOut  = {$urandom, $urandom};
    ALU_res = {$urandom, $urandom};
    r_data2 = {$urandom, $urandom};
    Z = 1'($urandom); rd = 5'($urandom);
    {MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ} = 7'($urandom);
  endtask

  task automatic run_txn(input op_t o, input bit noise, output obs_t r);
    int idx;
    r = '{default: 0};
    r.hold_ok = 1'b1; r.busy_ok = 1'b1; r.pulse_ok = 1'b1;
    @(negedge clk);
    ALUOut = o.alu; ALU_res = o.tgt; r_data2 = o.wdata; Z = o.z; rd = o.rd;
    {MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ} = o.c;
    ex_valid = 1'b1;
    dm_ready = noise ? 1'($urandom) : 1'b0;
    idx = 0;
    for (int n = 1; n <= 40 && !r.got; n++) begin
      @(negedge clk);
      if (n == 1) scramble_inputs();
      if (wb_valid) begin
        r.got = 1'b1; r.lat = n;
        r.wb_data = wb_data; r.wb_rd = wb_rd; r.rw = wb_RegWrite; r.pcs = PCSrc;
        r.br_target = br_target; r.al = align_err; r.be = bus_err;
        if (ex_ready || dm_req) r.busy_ok = 1'b0;
        ex_valid = 1'b0;
        dm_ready = noise ? 1'($urandom) : 1'b0;
      end else begin
        if (ex_ready) r.busy_ok = 1'b0;
        ex_valid = noise ? 1'($urandom) : 1'b0;
        if (dm_req) begin
          r.req++;
          if (dm_addr !== o.alu || dm_we !== o.c[5] || dm_wdata !== o.wdata) r.hold_ok = 1'b0;
          dm_ready = (idx == o.dly);
          dm_rdata = (idx == o.dly) ? o.rdata : {$urandom, $urandom};
          idx++;
        end else begin
          dm_ready = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (wb_valid || PCSrc || align_err || bus_err || !ex_ready || dm_req) r.pulse_ok = 1'b0;
    dm_ready = 1'b0;
  endtask

  task automatic run_and_check(input op_t o, input exp_t e, input string nm, input bit noise);
    obs_t r;
    run_txn(o, noise, r);
    chk({nm, ".wb_seen"}, 64'(r.got), 64'd1);
    if (e.rw) chk({nm, ".wb_data"}, r.wb_data, e.wb_data);
    chk({nm, ".wb_rd"}, 64'(r.wb_rd), 64'(e.wb_rd));
    chk({nm, ".wb_RegWrite"}, 64'(r.rw), 64'(e.rw));
    chk({nm, ".PCSrc"}, 64'(r.pcs), 64'(e.pcs));
    chk({nm, ".br_target"}, r.br_target, o.tgt);
    chk({nm, ".align_err"}, 64'(r.al), 64'(e.al));
    chk({nm, ".bus_err"}, 64'(r.be), 64'(e.be));
    chk({nm, ".req_cycles"}, 64'(r.req), 64'(e.req));
    chk({nm, ".latency"}, 64'(r.lat), 64'(e.lat));
    chk({nm, ".req_hold"}, 64'(r.hold_ok), 64'd1);
    chk({nm, ".ex_ready_busy"}, 64'(r.busy_ok), 64'd1);
    chk({nm, ".pulse_end"}, 64'(r.pulse_ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    op_t  o;

    tbl[0]  = '{mk_op(64'd96, 64'd0, 64'h1234, 64'd0, 1'b0, 5'd11, C_STUR, 2),
                mk_exp(64'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 3, 4)};
    tbl[1]  = '{mk_op(64'd88, 64'd0, 64'd0, 64'hDEAD, 1'b0, 5'd9, C_LDUR, 0),
                mk_exp(64'hDEAD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2)};
    tbl[2]  = '{mk_op(64'd28, 64'd0, 64'd0, 64'd0, 1'b0, 5'd10, C_ADD, 0),
                mk_exp(64'd28, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1)};
    tbl[3]  = '{mk_op(64'd0, 64'd180, 64'd0, 64'd0, 1'b1, 5'd0, C_CBZ, 0),
                mk_exp(64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1)};
    tbl[4]  = '{mk_op(64'd0, 64'd200, 64'd0, 64'd0, 1'b1, 5'd0, C_CBNZ, 0),
                mk_exp(64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1)};
    tbl[5]  = '{mk_op(64'd0, 64'd204, 64'd0, 64'd0, 1'b0, 5'd0, C_CBNZ, 0),
                mk_exp(64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1)};
    tbl[6]  = '{mk_op(64'd0, 64'h400, 64'd0, 64'd0, 1'b0, 5'd0, C_B, 0),
                mk_exp(64'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1)};
    tbl[7]  = '{mk_op(64'd86, 64'd0, 64'd0, 64'd0, 1'b0, 5'd9, C_LDUR, 0),
                mk_exp(64'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1)};
    tbl[8]  = '{mk_op(64'd64, 64'd0, 64'd0, 64'd0, 1'b0, 5'd5, C_LDUR, NEVER),
                mk_exp(64'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16, 17)};
    tbl[9]  = '{mk_op(64'h100, 64'd0, 64'd0, 64'hBEEF, 1'b0, 5'd3, C_LDUR, 15),
                mk_exp(64'hBEEF, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16, 17)};
    tbl[10] = '{mk_op(64'd3, 64'd0, 64'h55, 64'd0, 1'b0, 5'd7, C_STUR, 0),
                mk_exp(64'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1)};

    rst = 1'b1; ex_valid = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.ex_ready", 64'(ex_ready), 64'd1);
    chk("reset.dm_req", 64'(dm_req), 64'd0);
    chk("reset.dm_we", 64'(dm_we), 64'd0);
    chk("reset.dm_addr", dm_addr, 64'd0);
    chk("reset.wb_valid", 64'(wb_valid), 64'd0);
    chk("reset.wb_RegWrite", 64'(wb_RegWrite), 64'd0);
    chk("reset.wb_data", wb_data, 64'd0);
    chk("reset.PCSrc", 64'(PCSrc), 64'd0);
    chk("reset.br_target", br_target, 64'd0);
    chk("reset.errs", 64'({align_err, bus_err}), 64'd0);

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("vec%0d.model", i), 64'(predict(tbl[i].op).lat), 64'(tbl[i].e.lat));
      run_and_check(tbl[i].op, tbl[i].e, $sformatf("vec%0d", i), 1'b0);
    end

    // Reset asserted during the third dm_req cycle of a load.
    @(negedge clk);
    ALUOut = 64'd64; rd = 5'd4;
    {MemRead, MemWrite, MemtoReg, RegWrite, Branch, UncondBranch, CBNZ} = C_LDUR;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstmid.req1", 64'(dm_req), 64'd1);
    repeat (2) @(negedge clk);
    chk("rstmid.req3", 64'(dm_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.dm_req", 64'(dm_req), 64'd0);
    chk("rstmid.ex_ready", 64'(ex_ready), 64'd1);
    chk("rstmid.wb_valid", 64'(wb_valid), 64'd0);
    chk("rstmid.bus_err", 64'(bus_err), 64'd0);
    @(negedge clk);
    chk("rstmid.wb_valid2", 64'(wb_valid | bus_err | align_err), 64'd0);
    o = mk_op(64'd77, 64'd0, 64'd0, 64'd0, 1'b0, 5'd12, C_ADD, 0);
    run_and_check(o, mk_exp(64'd77, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1), "rstmid.add", 1'b0);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom % 5);
      o = mk_op({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom), 5'($urandom), C_ADD, 0);
      case (k)
        0: o.c = C_ADD;
        1: o.c = C_LDUR;
        2: o.c = C_STUR;
        3: o.c = ($urandom % 2) ? C_CBNZ : C_CBZ;
        default: o.c = C_B;
      endcase
      if ((k == 1 || k == 2) && ($urandom % 4 != 0)) o.alu[2:0] = 3'b000;
      o.dly = int'($urandom_range(0, TIMEOUT + 1));
      if (o.dly >= TIMEOUT) o.dly = NEVER;
      run_and_check(o, predict(o), $sformatf("rand%0d", i), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
